virq_inject: RTL
================

// Module: virq_inject
// PURPOSE
//  Guest-side counterpart of the trap/NMI controller. Trapping carries events guest -> hypervisor
//  via NMI; this block carries them back: the hypervisor queues a virtual maskable interrupt
//  while trapped, and the block delivers it to the guest Z80 as an IM2 INT with a supplied vector.
//  Sits beside the trap controller on the Nabu CPLD, between hypervisor I/O decode and CPU /INT.
// PARAMETERS
//  DELAY_W         4       width of the post-untrap delay counter (counts guest M1 cycles)
//  TIMEOUT_CYCLES  4096    clk cycles INT may stay asserted unacknowledged (VIRQ_TIMEOUT_EN only)
//  RESET_VECTOR    8'hFF   vector register value after reset
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous reset, active-high
//  reg_wr      in   1  one-clk write strobe from hypervisor I/O decode
//  reg_sel     in   2  register select: 0=VECTOR, 1=CTRL, 2=STATUS (read-only)
//  wr_data     in   8  write data
//  rd_data     out  8  read data for reg_sel (combinational mux)
//  trap_state  in   1  1 = hypervisor running (trapped), 0 = guest running
//  m1_n        in   1  CPU /M1, synchronised to clk upstream
//  iorq_n      in   1  CPU /IORQ, synchronised to clk upstream
//  int_n       out  1  to CPU /INT, active-low
//  vec_oe      out  1  drive vec_out onto the data bus during interrupt acknowledge
//  vec_out     out  8  IM2 vector byte
// BEHAVIOUR
//  - Reset: int_n=1, vec_oe=0, vec_out=RESET_VECTOR, state=IDLE, delay cnt=0, DONE/TMO flags=0.
//  - CTRL write: bit0 ARM, bit1 CANCEL, bits[3+DELAY_W:4] delay (M1 cycles after untrap).
//  - STATUS: bit0 busy (state!=IDLE), bit1 DONE (sticky, cleared on ARM), bit2 TMO, bits[6:4] state.
//  - VECTOR write accepted only in IDLE; ignored otherwise. vec_out always reflects VECTOR.
//  - FSM (all transitions on clk):
//    IDLE   -ARM->  ARMED (delay latched, DONE cleared)
//    ARMED  -trap_state==0-> DELAY; if ARM written while guest already running, enter DELAY next clk
//    DELAY  -count m1_n falling edges; at count==delay (0 => immediate)-> ASSERT
//    ASSERT int_n=0; ack (m1_n==0 && iorq_n==0) -> ACK; trap_state rising -> int_n=1, back to ARMED
//    ACK    int_n=1, vec_oe=1 while iorq_n==0; iorq_n rising -> IDLE, DONE=1 (vec_oe=0 same clk)
//  - CANCEL: from ARMED/DELAY/ASSERT -> IDLE next clk, int_n=1, DONE unchanged. In ACK: ignored.
//  - ARM and CANCEL in the same write: CANCEL wins. ARM while not IDLE: ignored.
//  - trap_state rising in DELAY: counter reset, back to ARMED (delay restarts after next untrap).
//  - Ack and trap_state rising in same clk during ASSERT: ack wins (vector must be served).
//  - Delay counter saturates; no wrap. Async rst mid-ACK drops vec_oe immediately.
// CONFIGURATION
//  VIRQ_TIMEOUT_EN defined: clk counter runs in ASSERT; reaching TIMEOUT_CYCLES -> int_n=1,
//    state IDLE, STATUS.TMO=1 (cleared on next ARM). Counter clears on leaving ASSERT.
//  Not defined: no counter logic; ASSERT held until ack/cancel/trap; STATUS bit2 reads 0.
// STRUCTURE
//  Shared header virq_defs.vh: state encodings (IDLE/ARMED/DELAY/ASSERT/ACK), reg_sel addresses,
//    CTRL/STATUS bit positions.
//  One sub-module: m1_edge_det (registers m1_n, emits one-clk pulse on falling edge), feeds DELAY.
// TESTING
//  1 VECTOR=8'h40, CTRL=8'h01 while trap_state=1; drop trap_state -> int_n=0 within 2 clk;
//    ack cycle -> vec_oe=1, vec_out=8'h40; iorq_n rise -> IDLE, STATUS=8'h02.
//  2 CTRL=8'h31 (delay 3), untrap -> int_n stays 1 through 2 M1 falls, goes 0 after the 3rd.
//  3 In ASSERT raise trap_state -> int_n=1 next clk, STATUS state=ARMED; untrap -> re-asserts.
//  4 CTRL=8'h03 from IDLE -> stays IDLE; CANCEL in ASSERT -> int_n=1, DONE=0; CANCEL in ACK ignored.
//  5 VECTOR write during ARMED ignored (vec_out unchanged); rst pulse mid-ACK -> vec_oe=0, int_n=1.
//  6 VIRQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> int_n=1 after 16 clk, STATUS=8'h04; undefined
//    build -> int_n remains 0 after 1000 clk.

Source files
------------

// File: rtl/virq_inject_pkg.sv
// Shared definitions for the virtual-interrupt injector: FSM states, register
// addresses, CTRL/STATUS bit positions and the STATUS byte builder.
package virq_inject_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_ASSERT = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam logic [1:0] SEL_VECTOR = 2'd0;
    localparam logic [1:0] SEL_CTRL   = 2'd1;
    localparam logic [1:0] SEL_STATUS = 2'd2;

    localparam int CTRL_ARM_BIT    = 0;
    localparam int CTRL_CANCEL_BIT = 1;
    localparam int CTRL_DELAY_LSB  = 4;

    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;
    localparam int STAT_TMO_BIT    = 2;
    localparam int STAT_STATE_LSB  = 4;

    function automatic logic [7:0] status_byte(input state_t st, input logic done, input logic tmo);
        logic [7:0] b;
        b                         = '0;
        b[STAT_BUSY_BIT]          = (st != ST_IDLE);
        b[STAT_DONE_BIT]          = done;
        b[STAT_TMO_BIT]           = tmo;
        b[STAT_STATE_LSB +: 3]    = st;
        return b;
    endfunction

endpackage

// File: rtl/virq_inject_if.sv
// Hypervisor register bus into the injector: one-clk write strobe, select,
// write data and a combinational read-back.
interface virq_inject_if;
    logic       reg_wr;
    logic [1:0] reg_sel;
    logic [7:0] wr_data;
    logic [7:0] rd_data;

    modport master (output reg_wr, output reg_sel, output wr_data, input rd_data);
    modport slave  (input reg_wr, input reg_sel, input wr_data, output rd_data);
endinterface

// File: rtl/virq_inject_m1_edge_det.sv
// Registers the synchronised /M1 and emits a one-clk pulse on its falling edge.
module virq_inject_m1_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_m1_n,
    output logic o_fall
);
    logic r_m1_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_m1_n <= 1'b1;
        else     r_m1_n <= i_m1_n;
    end

    assign o_fall = r_m1_n & ~i_m1_n;
endmodule

// File: rtl/virq_inject.sv
// Delivers a hypervisor-queued virtual IM2 interrupt to the guest Z80 after untrap.
// Optional unacknowledged-INT timeout is built when VIRQ_TIMEOUT_EN is defined.
module virq_inject
    import virq_inject_pkg::*;
#(
    parameter int         DELAY_W        = 4,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [7:0] RESET_VECTOR   = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    virq_inject_if.slave       io_reg,
    input  logic               i_trap_state,
    input  logic               i_m1_n,
    input  logic               i_iorq_n,
    output logic               o_int_n,
    output logic               o_vec_oe,
    output logic [7:0]         o_vec_out
);
    state_t               r_state, w_next;
    logic [7:0]           r_vector;
    logic [DELAY_W-1:0]   r_delay, r_cnt;
    logic                 r_done;
    logic                 w_m1_fall, w_ctrl_wr, w_arm, w_cancel, w_ack;
    logic                 w_tmo_hit, w_tmo_flag;

    function automatic logic [DELAY_W-1:0] sat_inc(input logic [DELAY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    virq_inject_m1_edge_det u_m1_edge (
        .clk    (clk),
        .rst    (rst),
        .i_m1_n (i_m1_n),
        .o_fall (w_m1_fall)
    );

    assign w_ctrl_wr = io_reg.reg_wr && (io_reg.reg_sel == SEL_CTRL);
    assign w_cancel  = w_ctrl_wr && io_reg.wr_data[CTRL_CANCEL_BIT];
    assign w_arm     = w_ctrl_wr && io_reg.wr_data[CTRL_ARM_BIT] && !io_reg.wr_data[CTRL_CANCEL_BIT];
    assign w_ack     = !i_m1_n && !i_iorq_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Ack outranks cancel, trap and timeout in ASSERT so a started acknowledge always gets its vector.
    always_comb begin
        w_next   = r_state;
        o_int_n  = 1'b1;
        o_vec_oe = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_arm) w_next = ST_ARMED;
            ST_ARMED: begin
                if (w_cancel)           w_next = ST_IDLE;
                else if (!i_trap_state) w_next = ST_DELAY;
            end
            ST_DELAY: begin
                if (w_cancel)               w_next = ST_IDLE;
                else if (i_trap_state)      w_next = ST_ARMED;
                else if (r_cnt == r_delay)  w_next = ST_ASSERT;
            end
            ST_ASSERT: begin
                o_int_n = 1'b0;
                if (w_ack)             w_next = ST_ACK;
                else if (w_cancel)     w_next = ST_IDLE;
                else if (i_trap_state) w_next = ST_ARMED;
                else if (w_tmo_hit)    w_next = ST_IDLE;
            end
            ST_ACK: begin
                o_vec_oe = !i_iorq_n;
                if (i_iorq_n) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vector <= RESET_VECTOR;
            r_delay  <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            if (io_reg.reg_wr && (io_reg.reg_sel == SEL_VECTOR) && (r_state == ST_IDLE))
                r_vector <= io_reg.wr_data;
            if ((r_state == ST_IDLE) && w_arm)
                r_delay <= io_reg.wr_data[CTRL_DELAY_LSB +: DELAY_W];
            if (w_next != ST_DELAY)
                r_cnt <= '0;
            else if ((r_state == ST_DELAY) && w_m1_fall)
                r_cnt <= sat_inc(r_cnt);
            if ((r_state == ST_ACK) && (w_next == ST_IDLE))
                r_done <= 1'b1;
            else if ((r_state == ST_IDLE) && w_arm)
                r_done <= 1'b0;
        end
    end

`ifdef VIRQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo;

    assign w_tmo_hit  = (r_state == ST_ASSERT) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_tmo_flag = r_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else begin
            if ((r_state == ST_ASSERT) && (w_next == ST_ASSERT)) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                                                 r_tmo_cnt <= '0;
            if (w_tmo_hit && (w_next == ST_IDLE) && !w_ack && !w_cancel && !i_trap_state)
                r_tmo <= 1'b1;
            else if ((r_state == ST_IDLE) && w_arm)
                r_tmo <= 1'b0;
        end
    end
`else
    // Timeout hardware absent; the parameter is still accepted so both builds share one interface.
    logic w_unused_tmo_cfg;
    assign w_unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign w_tmo_hit        = 1'b0;
    assign w_tmo_flag       = 1'b0;
`endif

    always_comb begin
        io_reg.rd_data = '0;
        case (io_reg.reg_sel)
            SEL_VECTOR: io_reg.rd_data = r_vector;
            SEL_CTRL:   io_reg.rd_data[CTRL_DELAY_LSB +: DELAY_W] = r_delay;
            SEL_STATUS: io_reg.rd_data = status_byte(r_state, r_done, w_tmo_flag);
            default:    ;
        endcase
    end

    assign o_vec_out = r_vector;
endmodule
